// File: rtl/crossbar_4x4_4bit.sv
// Purpose: 4x4 lane crossbar from five 2x2 straight/cross cells in a Benes-style arrangement.
// Latency: one core clock; the routed lanes are captured into output registers.
// Backpressure: none; a new control word and new data are accepted on every clock.
module crossbar_4x4_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [4:0]       control,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4
);

    // Cell outputs, named <cell>_o1 / <cell>_o2.
    logic [WIDTH-1:0] s0_o1, s0_o2;
    logic [WIDTH-1:0] s1_o1, s1_o2;
    logic [WIDTH-1:0] s2_o1, s2_o2;
    logic [WIDTH-1:0] out1_d, out2_d, out3_d, out4_d;
    logic [WIDTH-1:0] out1_q, out2_q, out3_q, out4_q;

    // Input stage: S0 pairs lanes 1/2, S1 pairs lanes 3/4.
    always_comb begin
        s0_o1 = control[0] ? in2 : in1;
        s0_o2 = control[0] ? in1 : in2;
        s1_o1 = control[1] ? in4 : in3;
        s1_o2 = control[1] ? in3 : in4;
    end

    // Middle cell S2 exchanges between the upper and lower halves.
    always_comb begin
        s2_o1 = control[2] ? s1_o1 : s0_o2;
        s2_o2 = control[2] ? s0_o2 : s1_o1;
    end

    // Output stage: S3 drives lanes 1/2, S4 drives lanes 3/4.
    always_comb begin
        out1_d = control[3] ? s2_o1 : s0_o1;
        out2_d = control[3] ? s0_o1 : s2_o1;
        out3_d = control[4] ? s1_o2 : s2_o2;
        out4_d = control[4] ? s2_o2 : s1_o2;
    end

    // Capture routed lanes; reset clears them immediately, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_q <= '0;
            out2_q <= '0;
            out3_q <= '0;
            out4_q <= '0;
        end else begin
            out1_q <= out1_d;
            out2_q <= out2_d;
            out3_q <= out3_d;
            out4_q <= out4_d;
        end
    end

    assign out1 = out1_q;
    assign out2 = out2_q;
    assign out3 = out3_q;
    assign out4 = out4_q;

endmodule

// File: tb/tb_crossbar_4x4_4bit.sv
module tb_crossbar_4x4_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] in1, in2, in3, in4;
    logic [4:0] control;
    logic [3:0] out1, out2, out3, out4;

    logic [7:0] w_in1, w_in2, w_in3, w_in4;
    logic [4:0] w_control;
    logic [7:0] w_out1, w_out2, w_out3, w_out4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb_q[$];

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [15:0] ins;   // {in1,in2,in3,in4}
        logic [15:0] exp;   // {out1,out2,out3,out4}
    } vec_t;

    crossbar_4x4_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .control(control),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4)
    );

    crossbar_4x4_4bit #(.WIDTH(8)) dut_w8 (
        .clk(clk), .rst_n(rst_n),
        .in1(w_in1), .in2(w_in2), .in3(w_in3), .in4(w_in4),
        .control(w_control),
        .out1(w_out1), .out2(w_out2), .out3(w_out3), .out4(w_out4)
    );

    always #5 clk = ~clk;

    // Reference routing: lanes tracked by position, each cell either keeps or swaps its pair.
    function automatic logic [15:0] model(input logic [4:0] c, input logic [15:0] ins);
        logic [3:0] l [4];
        logic [3:0] m [4];
        logic [3:0] t;
        l[0] = ins[15:12]; l[1] = ins[11:8]; l[2] = ins[7:4]; l[3] = ins[3:0];
        if (c[0]) begin t = l[0]; l[0] = l[1]; l[1] = t; end
        if (c[1]) begin t = l[2]; l[2] = l[3]; l[3] = t; end
        // middle cell sees lane-1 (upper second) and lane-2 (lower first)
        if (c[2]) begin t = l[1]; l[1] = l[2]; l[2] = t; end
        m[0] = l[0]; m[1] = l[1]; m[2] = l[2]; m[3] = l[3];
        if (c[3]) begin m[0] = l[1]; m[1] = l[0]; end
        if (c[4]) begin m[2] = l[3]; m[3] = l[2]; end
        return {m[0], m[1], m[2], m[3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {out1, out2, out3, out4};
    endfunction

    // One pipelined cycle: compare the capture from the previous cycle, then drive new stimulus.
    task automatic cycle(input string name, input logic [4:0] c, input logic [15:0] ins,
                         input logic [15:0] exp);
        @(negedge clk);
        if (sb_q.size() > 0) check(name, {16'h0, outs()}, {16'h0, sb_q.pop_front()});
        control = c;
        {in1, in2, in3, in4} = ins;
        sb_q.push_back(exp);
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        if (sb_q.size() > 0) check(name, {16'h0, outs()}, {16'h0, sb_q.pop_front()});
    endtask

    initial begin
        vec_t tbl [8];
        logic [15:0] base;
        base = 16'h0123;
        tbl[0] = '{ctrl: 5'b00000, ins: base,    exp: 16'h0123};
        tbl[1] = '{ctrl: 5'b11111, ins: base,    exp: 16'h3120};
        tbl[2] = '{ctrl: 5'b00001, ins: base,    exp: 16'h1023};
        tbl[3] = '{ctrl: 5'b00100, ins: base,    exp: 16'h0213};
        tbl[4] = '{ctrl: 5'b01000, ins: base,    exp: 16'h1023};
        tbl[5] = '{ctrl: 5'b10000, ins: base,    exp: 16'h0132};
        tbl[6] = '{ctrl: 5'b00010, ins: base,    exp: 16'h0132};
        tbl[7] = '{ctrl: 5'b00011, ins: 16'h59C7, exp: 16'h957C};

        control = 5'b00000;
        {in1, in2, in3, in4} = base;
        w_control = 5'b00100;
        w_in1 = 8'hA5; w_in2 = 8'h3C; w_in3 = 8'hFF; w_in4 = 8'h01;

        // Power-on reset: outputs clear without any clock.
        #1 rst_n = 1'b0;
        #1 check("reset_init", {16'h0, outs()}, 32'h0);
        @(posedge clk); #1;
        check("reset_hold", {16'h0, outs()}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_capture", {16'h0, outs()}, 32'h0000_0123);
        check("width8", {w_out1, w_out2, w_out3, w_out4}, 32'hA5FF_3C01);

        // Directed table, one vector per cycle through the scoreboard.
        for (int i = 0; i < 8; i++) cycle($sformatf("table%0d", i), tbl[i].ctrl, tbl[i].ins, tbl[i].exp);
        drain("table_last");

        // Full control sweep: model result and permutation property.
        for (int c = 0; c < 32; c++) begin
            logic [3:0] mask;
            cycle($sformatf("sweep%0d", c), c[4:0], base, model(c[4:0], base));
            mask = 4'h0;
            mask[out1[1:0]] = 1'b1; mask[out2[1:0]] = 1'b1;
            mask[out3[1:0]] = 1'b1; mask[out4[1:0]] = 1'b1;
            if (c > 0) check($sformatf("perm%0d", c), {28'h0, mask}, 32'hF);
        end
        drain("sweep_last");

        // Latency: control changes just after an edge, outputs only move on the next edge.
        @(negedge clk) control = 5'b00000;
        @(posedge clk); #1;
        control = 5'b11111;
        #1 check("lat_hold", {16'h0, outs()}, 32'h0000_0123);
        @(negedge clk);
        check("lat_hold_neg", {16'h0, outs()}, 32'h0000_0123);
        @(posedge clk); #1;
        check("lat_update", {16'h0, outs()}, 32'h0000_3120);

        // Mid-run reset with nonzero outputs: immediate clear, held across edges.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 check("reset_async", {16'h0, outs()}, 32'h0);
        check("reset_async_w8", {w_out1, w_out2, w_out3, w_out4}, 32'h0);
        @(posedge clk); #1;
        check("reset_held", {16'h0, outs()}, 32'h0);
        @(negedge clk);
        control = 5'b00000;
        rst_n = 1'b1;
        check("reset_no_capture", {16'h0, outs()}, 32'h0);
        @(posedge clk); #1;
        check("reset_release", {16'h0, outs()}, 32'h0000_0123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
